if_stage: RTL and testbench

Instruction-fetch stage for the single-cycle MIPS core. Owns the program counter, drives the synchronous instruction memory (one-cycle read latency), and presents one instruction at a time to the decode/execute logic through a valid/ready handshake. Applies branch/jump redirects supplied by execute when the current instruction retires, and optionally gates advancement on a debug single-step button.

---
 rtl/mips_pkg.sv | 16 +
 rtl/if_stage_step_sync.sv | 38 +++
 rtl/if_stage.sv | 102 ++++++++++
 tb/tb_if_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: fetch FSM encoding, reset vector and
// word-alignment helper.
`timescale 1ns/1ps
package mips_pkg;
   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      CAPTURE = 2'd1,
      HOLD    = 2'd2
   } fetch_state_t;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/if_stage_step_sync.sv
// Debug single-step conditioner: 2-flop synchronizer, rising-edge detector and
// a one-deep pending flag consumed by the fetch stage when it advances.
`timescale 1ns/1ps
module step_sync (
   input  logic clk,
   input  logic rst,
   input  logic debug_en,
   input  logic debug_step,
   input  logic advance,
   output logic pending
);
   // [1:0] synchronizer, [2] previous synchronized value for edge detection
   logic [2:0] r_sync;
   logic       r_pending;
   logic       w_rise;

   assign w_rise  = r_sync[1] & ~r_sync[2];
   assign pending = r_pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= 3'b000;
      end else begin
         r_sync <= {r_sync[1:0], debug_step};
      end
   end

   // Edges landing while already pending, or in the advance cycle, are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= 1'b0;
      end else if (!debug_en || advance) begin
         r_pending <= 1'b0;
      end else if (w_rise) begin
         r_pending <= 1'b1;
      end
   end
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, synchronous instruction-memory access and a
// valid/ready instruction handshake. DEBUG_STEP_EN adds single-step gating.
`timescale 1ns/1ps
module if_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
   parameter int          IM_ADDR_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 im_en,
   output logic [IM_ADDR_W-1:0] im_addr,
   input  logic [31:0]          im_data,
   output logic [31:0]          inst,
   output logic [31:0]          pc,
   output logic [31:0]          pc_plus4,
   output logic                 inst_valid,
   input  logic                 inst_ready,
   input  logic                 branch_taken,
   input  logic [31:0]          branch_target,
   input  logic                 jump,
   input  logic [31:0]          jump_target,
`ifdef DEBUG_STEP_EN
   input  logic                 debug_en,
   input  logic                 debug_step,
`endif
   output logic [31:0]          fetch_count
);
   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  r_inst;
   logic         r_inst_valid;
   logic [31:0]  r_fetch_count;
   logic [31:0]  w_pc_plus4;
   logic [31:0]  w_next_pc;
   logic         w_step_ok;
   logic         w_advance;

`ifdef DEBUG_STEP_EN
   logic w_pending;

   step_sync u_step_sync (
      .clk        (clk),
      .rst        (rst),
      .debug_en   (debug_en),
      .debug_step (debug_step),
      .advance    (w_advance),
      .pending    (w_pending)
   );

   assign w_step_ok = !debug_en || w_pending;
`else
   assign w_step_ok = 1'b1;
`endif

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_advance  = (r_state == HOLD) && inst_ready && w_step_ok;
   assign w_next_pc  = align_word(jump         ? jump_target   :
                                  branch_taken ? branch_target : w_pc_plus4);

   assign im_en       = (r_state == FETCH);
   assign im_addr     = r_pc[IM_ADDR_W+1:2];
   assign inst        = r_inst;
   assign pc          = r_pc;
   assign pc_plus4    = w_pc_plus4;
   assign inst_valid  = r_inst_valid;
   assign fetch_count = r_fetch_count;

   // Memory data arrives during CAPTURE; redirects only matter on advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= FETCH;
         r_pc          <= RESET_PC;
         r_inst        <= 32'd0;
         r_inst_valid  <= 1'b0;
         r_fetch_count <= 32'd0;
      end else begin
         case (r_state)
            FETCH: begin
               r_state <= CAPTURE;
            end
            CAPTURE: begin
               r_inst       <= im_data;
               r_inst_valid <= 1'b1;
               r_state      <= HOLD;
            end
            HOLD: begin
               if (w_advance) begin
                  r_pc          <= w_next_pc;
                  r_inst_valid  <= 1'b0;
                  r_fetch_count <= r_fetch_count + 32'd1;
                  r_state       <= FETCH;
               end
            end
            default: begin
               r_state <= FETCH;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_if_stage.sv
// Directed scoreboard bench for if_stage: expected fetch PCs are queued when a
// retire is driven and compared when the instruction shows up as valid.
`timescale 1ns/1ps
module tb_if_stage;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          im_en;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_data;
   logic [31:0]   inst;
   logic [31:0]   pc;
   logic [31:0]   pc_plus4;
   logic          inst_valid;
   logic          inst_ready;
   logic          branch_taken;
   logic [31:0]   branch_target;
   logic          jump;
   logic [31:0]   jump_target;
   logic [31:0]   fetch_count;
`ifdef DEBUG_STEP_EN
   logic          debug_en;
   logic          debug_step;
`endif

   logic [31:0] mem [16];
   logic [31:0] exp_q [$];
   logic [31:0] model_pc;
   logic [31:0] exp_count;
   int          tests = 0;
   int          fails = 0;

   if_stage #(.RESET_PC(32'h0000_0000), .IM_ADDR_W(AW)) dut (
      .clk           (clk),
      .rst           (rst),
      .im_en         (im_en),
      .im_addr       (im_addr),
      .im_data       (im_data),
      .inst          (inst),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .inst_valid    (inst_valid),
      .inst_ready    (inst_ready),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
`ifdef DEBUG_STEP_EN
      .debug_en      (debug_en),
      .debug_step    (debug_step),
`endif
      .fetch_count   (fetch_count)
   );

   always #5 clk = ~clk;

   // Synchronous instruction memory, one-cycle read latency.
   always @(posedge clk) begin
      if (im_en) im_data <= mem[im_addr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] mem_at(input logic [31:0] a);
      return mem[a[5:2]];
   endfunction

   // Called at the negedge of a FETCH cycle; ends at the first HOLD negedge.
   task automatic fetch_and_check(input string tag);
      logic [31:0] p;
      p = exp_q[0];
      check({tag, " im_en"}, {31'd0, im_en}, 32'd1);
      check({tag, " im_addr"}, 32'(im_addr), {28'd0, p[5:2]});
      @(negedge clk);
      check({tag, " valid@1"}, {31'd0, inst_valid}, 32'd0);
      @(negedge clk);
      inst_ready = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      check({tag, " valid@2"}, {31'd0, inst_valid}, 32'd1);
      p = exp_q.pop_front();
      model_pc = p;
      check({tag, " pc"}, pc, p);
      check({tag, " inst"}, inst, mem_at(p));
      check({tag, " pc_plus4"}, pc_plus4, p + 32'd4);
      $display("[TB] %s: pc=%h inst=%h count=%0d", tag, pc, inst, fetch_count);
   endtask

   // Called at a HOLD negedge; retires the current instruction with the given redirect.
   task automatic retire(input string tag, input logic j, input logic [31:0] jt,
                         input logic b, input logic [31:0] bt);
      logic [31:0] n;
      n = j ? jt : (b ? bt : model_pc + 32'd4);
      n[1:0] = 2'b00;
      inst_ready = 1'b1; jump = j; jump_target = jt; branch_taken = b; branch_target = bt;
      exp_q.push_back(n);
      exp_count = exp_count + 32'd1;
      @(negedge clk);
      check({tag, " count"}, fetch_count, exp_count);
      check({tag, " valid0"}, {31'd0, inst_valid}, 32'd0);
      // Redirect noise outside HOLD must be ignored.
      inst_ready = 1'b1; jump = 1'b1; jump_target = 32'h3C; branch_taken = 1'b1; branch_target = 32'h38;
      fetch_and_check(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 | i;
      mem[0] = 32'h2000_0001;
      rst = 1'b1; inst_ready = 1'b0; jump = 1'b0; branch_taken = 1'b0;
      jump_target = 32'd0; branch_target = 32'd0;
`ifdef DEBUG_STEP_EN
      debug_en = 1'b0; debug_step = 1'b0;
`endif
      exp_count = 32'd0; model_pc = 32'd0;
      repeat (3) @(negedge clk);
      check("reset pc", pc, 32'd0);
      check("reset inst", inst, 32'd0);
      check("reset valid", {31'd0, inst_valid}, 32'd0);
      check("reset count", fetch_count, 32'd0);

      rst = 1'b0;
      exp_q.push_back(32'd0);
      fetch_and_check("boot");

      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("hold pc", pc, model_pc);
         check("hold inst", inst, mem_at(model_pc));
         check("hold valid", {31'd0, inst_valid}, 32'd1);
         check("hold count", fetch_count, 32'd0);
      end

      retire("seq", 1'b0, 32'd0, 1'b0, 32'd0);
      retire("jump_over_branch", 1'b1, 32'h0000_0020, 1'b1, 32'h0000_0010);
      retire("branch_unaligned", 1'b0, 32'd0, 1'b1, 32'h0000_0013);
      retire("jump_top", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
      retire("wrap", 1'b0, 32'd0, 1'b0, 32'd0);

      // Retire once more, then reset in the middle of the CAPTURE cycle.
      inst_ready = 1'b1;
      @(negedge clk);
      inst_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst pc", pc, 32'd0);
      check("midrst valid", {31'd0, inst_valid}, 32'd0);
      check("midrst inst", inst, 32'd0);
      check("midrst count", fetch_count, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      exp_q.push_back(32'd0);
      exp_count = 32'd0;
      fetch_and_check("restart");

`ifdef DEBUG_STEP_EN
      debug_en = 1'b1;
      inst_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("step gated valid", {31'd0, inst_valid}, 32'd1);
         check("step gated count", fetch_count, 32'd0);
      end
      debug_step = 1'b1;
      repeat (2) @(negedge clk);
      debug_step = 1'b0;
      for (int k = 0; k < 8 && inst_valid; k++) @(negedge clk);
      check("step1 count", fetch_count, 32'd1);
      check("step1 pc", pc, 32'd4);
      inst_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         debug_step = 1'b1; @(negedge clk);
         debug_step = 1'b0; @(negedge clk);
      end
      repeat (3) @(negedge clk);
      inst_ready = 1'b1;
      for (int k = 0; k < 8 && inst_valid; k++) @(negedge clk);
      check("burst count", fetch_count, 32'd2);
      check("burst pc", pc, 32'd8);
      repeat (10) @(negedge clk);
      check("burst single count", fetch_count, 32'd2);
      check("burst single valid", {31'd0, inst_valid}, 32'd1);
      debug_en = 1'b0;
      for (int k = 0; k < 8 && inst_valid; k++) @(negedge clk);
      check("free run count", fetch_count, 32'd3);
      $display("[TB] debug step: count=%0d pc=%h", fetch_count, pc);
      inst_ready = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
